// File: rtl/serial_pkg.sv
// Shared definitions for the parallel-to-serial front end: FSM state
// encoding and default parameter values used by bit_serializer.
package serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int   DEFAULT_WIDTH      = 8;
  localparam logic DEFAULT_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/bit_counter.sv
// Mod-WIDTH bit position counter. Clear has priority over enable; when
// enabled at the terminal count the counter wraps to zero, so it reads zero
// again once the last bit has been consumed.
module bit_counter #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     enable,
  output logic [$clog2(WIDTH)-1:0] count,
  output logic                     terminal
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  assign terminal = (count == LAST);

  // Count register: clear, wrap at terminal, or increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (terminal) count <= '0;
      else          count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end for the sequence detector. A word is
// captured on load while idle, then one bit is presented per step strobe on
// a registered output. done pulses for one cycle after the last bit.
//
//   state | meaning
//   ------+---------------------------------------------------
//   IDLE  | no word in flight, sout at IDLE_LEVEL, ready=1
//   SHIFT | word in flight, sout carries bit bit_idx
module bit_serializer
  import serial_pkg::*;
#(
  parameter int   WIDTH      = DEFAULT_WIDTH,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = DEFAULT_IDLE_LEVEL
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [WIDTH-1:0]         din,
  input  logic                     step,
  output logic                     sout,
  output logic                     sout_valid,
  output logic                     busy,
  output logic                     ready,
  output logic                     done,
  output logic [$clog2(WIDTH)-1:0] bit_idx
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_shifted;
  logic             shifted_head;
  logic             din_head;
  logic             accept;
  logic             advance;
  logic             last_bit;

  // Load is only honoured while idle; step only matters while shifting, so
  // a step in the load cycle is naturally ignored.
  assign accept  = (state == IDLE) && load;
  assign advance = (state == SHIFT) && step;

  // The shift register keeps the bit currently on sout at its head, so the
  // next bit is the head of the shifted value.
  assign shreg_shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                   : {1'b0, shreg[WIDTH-1:1]};
  assign shifted_head  = MSB_FIRST ? shreg_shifted[WIDTH-1] : shreg_shifted[0];
  assign din_head      = MSB_FIRST ? din[WIDTH-1] : din[0];

  bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (accept),
    .enable   (advance),
    .count    (bit_idx),
    .terminal (last_bit)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load) state_next = SHIFT;
      SHIFT:   if (step && last_bit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded directly from state.
  always_comb begin
    busy  = 1'b0;
    ready = 1'b0;
    case (state)
      IDLE:    ready = 1'b1;
      SHIFT:   busy  = 1'b1;
      default: ready = 1'b1;
    endcase
  end

  // Shift register and registered serial outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg      <= '0;
      sout       <= IDLE_LEVEL;
      sout_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        shreg      <= din;
        sout       <= din_head;
        sout_valid <= 1'b1;
      end else if (advance) begin
        if (last_bit) begin
          shreg      <= '0;
          sout       <= IDLE_LEVEL;
          sout_valid <= 1'b0;
          done       <= 1'b1;
        end else begin
          shreg <= shreg_shifted;
          sout  <= shifted_head;
        end
      end
    end
  end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
Parallel-to-serial front end that feeds the serial input of the sequence detector. It loads a WIDTH-bit word, then presents one bit per advance strobe on a single registered output that drives the detector's x input. It uses a load/ready handshake on the parallel side. It signals completion so a controller can queue the next word.

Parameters:
WIDTH, 8, number of bits per word (>= 2)
MSB_FIRST, 1, 1 = shift out din[WIDTH-1] first; 0 = din[0] first
IDLE_LEVEL, 1, value driven on sout whenever no word is being shifted

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset; clears all state immediately
load  in  1  request to capture din; honoured only when ready=1
din  in  WIDTH  parallel word to serialize
step  in  1  advance strobe; tie high for one bit per clock
sout  out  1  registered serial bit, connects to detector x
sout_valid  out  1  high while sout carries a data bit
busy  out  1  high in SHIFT state
ready  out  1  high in IDLE state (= ~busy)
done  out  1  one-cycle pulse after the last bit has been consumed
bit_idx  out  $clog2(WIDTH)  index (0-based, in shift order) of the bit now on sout

Behaviour:
- Reset (async, any time): state=IDLE, shift register=0, bit_idx=0, sout=IDLE_LEVEL, sout_valid=0, busy=0, ready=1, done=0. Reset mid-word aborts the word; no done pulse.
- States: IDLE, SHIFT.
- IDLE with load=1 at an edge: capture din, bit_idx<=0, go to SHIFT. First bit appears on sout in the next cycle with sout_valid=1 (1-cycle load latency). step is ignored in the load cycle.
- SHIFT with step=0: hold sout, bit_idx and shift register.
- SHIFT with step=1, bit_idx<WIDTH-1: shift one position in the configured direction, bit_idx<=bit_idx+1.
- SHIFT with step=1, bit_idx==WIDTH-1: go to IDLE. Next cycle: sout=IDLE_LEVEL, sout_valid=0, done=1 for exactly one cycle, ready=1.
- load while busy: ignored, with no side effects; din is not re-sampled.
- load in the done cycle: accepted, because ready=1. Minimum word-to-word gap is therefore one cycle at IDLE_LEVEL.
- With step tied high, each word occupies exactly WIDTH cycles of sout_valid=1.
- bit_idx never exceeds WIDTH-1; it is 0 in IDLE.
- All outputs are registered or decoded directly from state. No combinational path from load, din or step to sout.

Decomposition:
- Shared package/include serial_pkg: state encoding (IDLE=1'b0, SHIFT=1'b1), default WIDTH=8, IDLE_LEVEL default.
- One sub-module: bit_counter. It is a mod-WIDTH counter with clear, enable and a terminal-count output, and it drives bit_idx and the last-bit decision.
- The shift register and FSM stay in bit_serializer.

Test Plan:
- Reset released, no load for 5 cycles -> sout=1, sout_valid=0, ready=1, done=0 throughout.
- MSB_FIRST=1, step=1, load din=8'b1011_0110 at cycle 0 -> sout=1,0,1,1,0,1,1,0 on cycles 1..8 with bit_idx 0..7; done=1 only at cycle 9; ready=1 at cycle 9.
- Same word with step high every 3rd cycle -> each bit held exactly 3 cycles; done exactly once after the 8th step.
- load din=8'hFF at cycle 3 of a word shifting 8'h00 -> ignored; sout stays 0 through bit 7; no restart.
- reset asserted at bit_idx=3, mid-cycle -> sout=1, busy=0, ready=1 immediately (async); no done pulse after release.
- MSB_FIRST=0, load 8'h01, then load 8'h80 in the done cycle -> 1,0,0,0,0,0,0,0, then one idle 1, then 0,0,0,0,0,0,0,1; two done pulses.
